reg_id_ex: RTL and testbench
============================

REG_ID_EX -- requirements
Module: reg_id_ex

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset as in the rest of the pipeline.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  pipeline clock, rising-edge.
- reset  in  1  async active-high reset.
- valid_i  in  1  ID stage holds a real instruction.
- pc_plus4_i  in  32  PC+4 of the ID instruction.
- rs_data_i, rt_data_i  in  32 each  register-file read data.
- imm_i  in  32  extended immediate.
- rs_i, rt_i, rd_i  in  5 each  register addresses.
- MemRd_i, MemWr_i, Branch_i, RegWr_i, ALUSrc_i  in  1 each  decoded control.
- MemtoReg_i, PCSrc_i, RegDst_i  in  2 each  decoded control.
- ALUCtl_i  in  5  ALU operation.
- flush_i  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- *_o  out  same widths  registered copies of every *_i above, including valid_o.
- load_use_stall_o  out  1  combinational; IF/ID register and PC hold this cycle.
- bubble_cnt_o  out  16  saturating count of inserted bubbles.

Function
REQ-003 Per rising clk edge, the register SHALL apply exactly one action, in this priority order: flush, then bubble, then load.
REQ-004 load_use_stall_o SHALL equal valid_o & MemRd_o & RegWr_o & (rt_o != 0) & valid_i & ((rt_o == rs_i) | (rt_o == rt_i)) & ~flush_i.
REQ-005 Flush (flush_i = 1) SHALL set every *_o output, including valid_o, to 0.
REQ-006 Bubble (load_use_stall_o = 1) SHALL set every *_o output, including valid_o, to 0.
REQ-007 Load (neither flush nor bubble) SHALL copy every *_i to its *_o with 1-cycle latency.
REQ-008 Load with valid_i = 0 SHALL still copy all inputs, but SHALL force all control outputs (MemRd, MemWr, Branch, RegWr, MemtoReg, PCSrc) to 0.
REQ-009 A stall SHALL last exactly one cycle per load-use pair: after the bubble, valid_o = 0, so REQ-004 deasserts.
REQ-010 When flush_i and a load-use match occur in the same cycle, the block SHALL perform a flush, hold load_use_stall_o at 0, and count one bubble.
REQ-011 bubble_cnt_o SHALL increment by 1 on each flush or bubble edge.
REQ-012 bubble_cnt_o SHALL saturate at 16'hFFFF and never wrap.
REQ-013 rd_i and RegDst_i SHALL NOT take part in hazard detection; a load writes rt only.
REQ-014 The block SHALL contain no other state; all outputs except load_use_stall_o SHALL be registers.

Reset
REQ-015 Asserting reset SHALL immediately, without waiting for clk, clear all *_o outputs, valid_o, and bubble_cnt_o to 0.
REQ-016 While reset is high, load_use_stall_o SHALL be 0 as a consequence of valid_o = 0.
REQ-017 Reset SHALL take priority over flush, bubble and load.
REQ-018 On the first rising clk edge after reset deasserts, the block SHALL perform a normal load.
REQ-019 Reset asserted in the middle of a stall SHALL cancel the stall; no pending bubble survives reset.

Verification
REQ-020 Load: valid_i=1, RegWr_i=1, rd_i=8, imm_i=32'h1234 -> one edge later RegWr_o=1, rd_o=8, imm_o=32'h1234, valid_o=1, bubble_cnt_o=0.
REQ-021 Load-use: EX holds lw (valid_o=1, MemRd_o=1, RegWr_o=1, rt_o=9); ID add has rs_i=9 -> load_use_stall_o=1; next edge valid_o=0 with all control 0, bubble_cnt_o=1; next cycle stall=0 and add loads.
REQ-022 Zero register: same as REQ-021 but rt_o=0, rs_i=0 -> load_use_stall_o=0 and no bubble.
REQ-023 Simultaneous: load-use match with flush_i=1 -> load_use_stall_o=0; next edge all outputs 0; bubble_cnt_o increments by exactly 1.
REQ-024 Saturation: preload bubble_cnt_o to 16'hFFFE, apply 3 flushes -> counter reads 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-025 Reset mid-op: during an active stall, pulse reset between clk edges -> all outputs 0 immediately, stall=0; the first edge after release loads ID contents.

Source files
------------

// File: rtl/reg_id_ex.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating count of inserted bubbles.
module reg_id_ex (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic        Branch_i,
  input  logic        RegWr_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  MemtoReg_i,
  input  logic [1:0]  PCSrc_i,
  input  logic [1:0]  RegDst_i,
  input  logic [4:0]  ALUCtl_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic        MemRd_o,
  output logic        MemWr_o,
  output logic        Branch_o,
  output logic        RegWr_o,
  output logic        ALUSrc_o,
  output logic [1:0]  MemtoReg_o,
  output logic [1:0]  PCSrc_o,
  output logic [1:0]  RegDst_o,
  output logic [4:0]  ALUCtl_o,
  output logic        load_use_stall_o,
  output logic [15:0] bubble_cnt_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        reg_wr;
    logic        alu_src;
    logic [1:0]  mem_to_reg;
    logic [1:0]  pc_src;
    logic [1:0]  reg_dst;
    logic [4:0]  alu_ctl;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        stall;
  logic        insert_bubble;

  // Valid semantics: valid_i marks a real instruction in ID; valid_o marks a
  // real instruction in EX. There is no back-pressure from EX; the only hold
  // signal is load_use_stall_o, which freezes IF/ID and the PC for one cycle.

  // A load in EX writes rt only; rd and RegDst never create a hazard.
  assign stall = stage_q.valid & stage_q.mem_rd & stage_q.reg_wr &
                 (stage_q.rt != 5'd0) & valid_i &
                 ((stage_q.rt == rs_i) | (stage_q.rt == rt_i)) & ~flush_i;

  assign insert_bubble = flush_i | stall;

  always_comb begin
    stage_d            = '0;
    stage_d.valid      = valid_i;
    stage_d.pc_plus4   = pc_plus4_i;
    stage_d.rs_data    = rs_data_i;
    stage_d.rt_data    = rt_data_i;
    stage_d.imm        = imm_i;
    stage_d.rs         = rs_i;
    stage_d.rt         = rt_i;
    stage_d.rd         = rd_i;
    stage_d.alu_src    = ALUSrc_i;
    stage_d.reg_dst    = RegDst_i;
    stage_d.alu_ctl    = ALUCtl_i;
    // Side-effecting controls are gated by valid so a dead slot cannot act.
    stage_d.mem_rd     = MemRd_i & valid_i;
    stage_d.mem_wr     = MemWr_i & valid_i;
    stage_d.branch     = Branch_i & valid_i;
    stage_d.reg_wr     = RegWr_i & valid_i;
    stage_d.mem_to_reg = MemtoReg_i & {2{valid_i}};
    stage_d.pc_src     = PCSrc_i & {2{valid_i}};
    bubble_cnt_d       = bubble_cnt_q;
    if (insert_bubble) begin
      stage_d = '0;
      if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o          = stage_q.valid;
  assign pc_plus4_o       = stage_q.pc_plus4;
  assign rs_data_o        = stage_q.rs_data;
  assign rt_data_o        = stage_q.rt_data;
  assign imm_o            = stage_q.imm;
  assign rs_o             = stage_q.rs;
  assign rt_o             = stage_q.rt;
  assign rd_o             = stage_q.rd;
  assign MemRd_o          = stage_q.mem_rd;
  assign MemWr_o          = stage_q.mem_wr;
  assign Branch_o         = stage_q.branch;
  assign RegWr_o          = stage_q.reg_wr;
  assign ALUSrc_o         = stage_q.alu_src;
  assign MemtoReg_o       = stage_q.mem_to_reg;
  assign PCSrc_o          = stage_q.pc_src;
  assign RegDst_o         = stage_q.reg_dst;
  assign ALUCtl_o         = stage_q.alu_ctl;
  assign load_use_stall_o = stall;
  assign bubble_cnt_o     = bubble_cnt_q;

endmodule

// File: tb/tb_reg_id_ex.sv
// Self-checking bench for reg_id_ex: directed hazard/flush/reset scenarios,
// randomized traffic against a behavioural model, and counter saturation.
module tb_reg_id_ex;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        memrd;
    logic        memwr;
    logic        branch;
    logic        regwr;
    logic        alusrc;
    logic [1:0]  memtoreg;
    logic [1:0]  pcsrc;
    logic [1:0]  regdst;
    logic [4:0]  aluctl;
  } bundle_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bundle_t in_b;
  logic    flush;

  logic        valid_o, MemRd_o, MemWr_o, Branch_o, RegWr_o, ALUSrc_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_o, rt_o, rd_o, ALUCtl_o;
  logic [1:0]  MemtoReg_o, PCSrc_o, RegDst_o;
  logic        load_use_stall_o;
  logic [15:0] bubble_cnt_o;
  bundle_t     out_b;

  assign out_b = {valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
                  MemRd_o, MemWr_o, Branch_o, RegWr_o, ALUSrc_o, MemtoReg_o, PCSrc_o,
                  RegDst_o, ALUCtl_o};

  reg_id_ex dut (
    .clk(clk), .reset(reset),
    .valid_i(in_b.valid), .pc_plus4_i(in_b.pc), .rs_data_i(in_b.rs_data),
    .rt_data_i(in_b.rt_data), .imm_i(in_b.imm), .rs_i(in_b.rs), .rt_i(in_b.rt),
    .rd_i(in_b.rd), .MemRd_i(in_b.memrd), .MemWr_i(in_b.memwr), .Branch_i(in_b.branch),
    .RegWr_i(in_b.regwr), .ALUSrc_i(in_b.alusrc), .MemtoReg_i(in_b.memtoreg),
    .PCSrc_i(in_b.pcsrc), .RegDst_i(in_b.regdst), .ALUCtl_i(in_b.aluctl),
    .flush_i(flush),
    .valid_o(valid_o), .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o),
    .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
    .MemRd_o(MemRd_o), .MemWr_o(MemWr_o), .Branch_o(Branch_o), .RegWr_o(RegWr_o),
    .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o), .PCSrc_o(PCSrc_o),
    .RegDst_o(RegDst_o), .ALUCtl_o(ALUCtl_o),
    .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // scoreboard
  int      n_checks = 0;
  int      n_errors = 0;
  bundle_t exp_b;
  int      exp_cnt;
  logic    exp_stall;
  logic [159:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: an EX slot is hazardous when it is a real load that
  // writes a nonzero rt read by the real instruction now in ID.
  function automatic logic model_stall(input bundle_t ex, input bundle_t id, input logic fl);
    logic reads_rt;
    reads_rt = (ex.rt == id.rs) || (ex.rt == id.rt);
    return ex.valid && ex.memrd && ex.regwr && ex.rt != 0 && id.valid && reads_rt && !fl;
  endfunction

  // driver tasks
  task automatic step(input string tag);
    bundle_t nxt;
    #1;
    exp_stall = model_stall(exp_b, in_b, flush);
    check({tag, "_stall"}, 160'(load_use_stall_o), 160'(exp_stall));
    if (flush || exp_stall) begin
      nxt = '0;
      exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
    end else begin
      nxt = in_b;
      if (!in_b.valid) begin
        nxt.memrd = 0; nxt.memwr = 0; nxt.branch = 0;
        nxt.regwr = 0; nxt.memtoreg = 0; nxt.pcsrc = 0;
      end
    end
    exp_q.push_back(160'(nxt));
    @(posedge clk);
    exp_b = nxt;
    #1;
    check({tag, "_regs"}, 160'(out_b), exp_q.pop_front());
    check({tag, "_cnt"}, 160'(bubble_cnt_o), 160'(exp_cnt));
  endtask

  // Pulses reset between clock edges and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_regs", 160'(out_b), 160'd0);
    check("rst_cnt", 160'(bubble_cnt_o), 160'd0);
    check("rst_stall", 160'(load_use_stall_o), 160'd0);
    #1;
    reset = 1'b0;
    exp_b = '0;
    exp_cnt = 0;
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b.valid = ($urandom_range(0, 9) < 8);
    b.rs = 5'($urandom_range(0, 3));
    b.rt = 5'($urandom_range(0, 3));
    b.memrd = $urandom_range(0, 1);
    b.regwr = $urandom_range(0, 3) != 0;
    return b;
  endfunction

  initial begin
    in_b = '0;
    flush = 1'b0;
    exp_b = '0;
    exp_cnt = 0;
    @(posedge clk);
    do_reset();

    // Plain load
    in_b = rand_bundle();
    in_b.valid = 1; in_b.regwr = 1; in_b.memrd = 0; in_b.rd = 5'd8; in_b.imm = 32'h1234;
    step("load");
    check("load_regwr", 160'(RegWr_o), 160'd1);
    check("load_rd", 160'(rd_o), 160'd8);
    check("load_imm", 160'(imm_o), 160'h1234);
    check("load_valid", 160'(valid_o), 160'd1);
    check("load_cnt", 160'(bubble_cnt_o), 160'd0);

    // Load-use on rs: one bubble, then the dependent instruction loads
    in_b = rand_bundle();
    in_b.valid = 1; in_b.memrd = 1; in_b.regwr = 1; in_b.rt = 5'd9;
    step("lw");
    in_b = rand_bundle();
    in_b.valid = 1; in_b.memrd = 0; in_b.rs = 5'd9; in_b.rt = 5'd3;
    #1;
    check("lu_stall_hi", 160'(load_use_stall_o), 160'd1);
    step("lu_bubble");
    check("lu_valid", 160'(valid_o), 160'd0);
    check("lu_cnt", 160'(bubble_cnt_o), 160'd1);
    step("lu_add");
    check("lu_add_valid", 160'(valid_o), 160'd1);
    check("lu_add_rs", 160'(rs_o), 160'd9);

    // Zero register never stalls
    in_b = rand_bundle();
    in_b.valid = 1; in_b.memrd = 1; in_b.regwr = 1; in_b.rt = 5'd0;
    step("lw0");
    in_b.memrd = 0; in_b.rs = 5'd0; in_b.rt = 5'd0;
    #1;
    check("zero_stall", 160'(load_use_stall_o), 160'd0);
    step("zero_add");
    check("zero_cnt", 160'(bubble_cnt_o), 160'd1);

    // Flush together with a load-use match: one bubble counted
    in_b = rand_bundle();
    in_b.valid = 1; in_b.memrd = 1; in_b.regwr = 1; in_b.rt = 5'd9;
    step("lw2");
    in_b.memrd = 0; in_b.rs = 5'd9;
    flush = 1'b1;
    #1;
    check("sim_stall", 160'(load_use_stall_o), 160'd0);
    step("sim");
    check("sim_regs", 160'(out_b), 160'd0);
    check("sim_cnt", 160'(bubble_cnt_o), 160'd2);
    flush = 1'b0;

    // Reset in the middle of a stall cancels it; next edge loads ID
    in_b = rand_bundle();
    in_b.valid = 1; in_b.memrd = 1; in_b.regwr = 1; in_b.rt = 5'd9;
    step("lw3");
    in_b.memrd = 0; in_b.rs = 5'd9;
    #1;
    check("mid_stall_hi", 160'(load_use_stall_o), 160'd1);
    do_reset();
    step("mid_load");
    check("mid_valid", 160'(valid_o), 160'd1);
    check("mid_rs", 160'(rs_o), 160'd9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_b = rand_bundle();
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      step("rnd");
    end
    flush = 1'b0;

    // Saturation: drive counter to FFFE, then three more flushes
    do_reset();
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) step("fill");
    check("sat_pre", 160'(bubble_cnt_o), 160'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step("sat");
      check("sat_val", 160'(bubble_cnt_o), 160'hFFFF);
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
